// File: rtl/test6_ecc_sram.sv
// 1024x32 SRAM with (39,32) SECDED protection and write-side data corruption.
// Reads are registered; decode and correction are combinational from the read register.
module test6_ecc_sram #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          W_EN,
  input  logic          R_EN,
  input  logic [AW-1:0] W_ADDR,
  input  logic [AW-1:0] R_ADDR,
  input  logic [DW-1:0] INn,
  input  logic [DW-1:0] selectt,
  output logic [DW-1:0] real_data,
  output logic [DW-1:0] wrong_real_data,
  output logic [AW-1:0] R_ADDRr
);

  localparam int CW = 39;

  logic [CW-1:0] mem_q [2**AW];
  logic [CW-1:0] rd_q, rd_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [CW-1:0] wr_cw;
  logic [CW-1:0] fix_cw;
  logic [5:0]    syn;
  logic          p_bad;

  // Checks come from clean data; only the stored data bits see the mask.
  function automatic logic [CW-1:0] encode(
    input logic [DW-1:0] d,
    input logic [DW-1:0] m
  );
    logic [CW-1:0] cl;
    logic [CW-1:0] c;
    logic          par;
    int            k;
    cl = '0;
    c  = '0;
    k  = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        cl[p-1] = d[k];
        c[p-1]  = d[k] ^ m[k];
        k++;
      end
    end
    for (int i = 0; i < 6; i++) begin
      par = 1'b0;
      for (int p = 1; p <= 38; p++) begin
        if (p[i]) par = par ^ cl[p-1];
      end
      cl[(1 << i) - 1] = par;
      c[(1 << i) - 1]  = par;
    end
    c[38] = ^cl[37:0];
    return c;
  endfunction

  function automatic logic [DW-1:0] extract(input logic [CW-1:0] c);
    logic [DW-1:0] d;
    int            k;
    d = '0;
    k = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = c[p-1];
        k++;
      end
    end
    return d;
  endfunction

  assign wr_cw = encode(INn, selectt);

  always_ff @(posedge clk) begin
    if (W_EN) mem_q[W_ADDR] <= wr_cw;
  end

  always_comb begin
    rd_d    = rd_q;
    raddr_d = raddr_q;
    if (R_EN) begin
      rd_d    = mem_q[R_ADDR];
      raddr_d = R_ADDR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      raddr_q <= '0;
    end else begin
      rd_q    <= rd_d;
      raddr_q <= raddr_d;
    end
  end

  // Syndrome is the XOR of the positions of all set bits in 1..38.
  always_comb begin
    syn = '0;
    for (int p = 1; p <= 38; p++) begin
      if (rd_q[p-1]) syn = syn ^ 6'(p);
    end
    p_bad  = ^rd_q;
    fix_cw = rd_q;
    if (syn != 6'd0 && p_bad && syn <= 6'd38) begin
      fix_cw[syn - 6'd1] = ~rd_q[syn - 6'd1];
    end
  end

  assign real_data       = extract(fix_cw);
  assign wrong_real_data = extract(rd_q);
  assign R_ADDRr         = raddr_q;

endmodule

// File: tb/tb_test6_ecc_sram.sv
// Random and directed bench for test6_ecc_sram against a data/mask
// reference model: single data flips are corrected, heavier damage passes through.
module tb_test6_ecc_sram;

  logic        clk;
  logic        rst_n;
  logic        W_EN;
  logic        R_EN;
  logic [9:0]  W_ADDR;
  logic [9:0]  R_ADDR;
  logic [31:0] INn;
  logic [31:0] selectt;
  logic [31:0] real_data;
  logic [31:0] wrong_real_data;
  logic [9:0]  R_ADDRr;

  test6_ecc_sram dut (
    .clk(clk),
    .rst_n(rst_n),
    .W_EN(W_EN),
    .R_EN(R_EN),
    .W_ADDR(W_ADDR),
    .R_ADDR(R_ADDR),
    .INn(INn),
    .selectt(selectt),
    .real_data(real_data),
    .wrong_real_data(wrong_real_data),
    .R_ADDRr(R_ADDRr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  logic [31:0] md [1024];
  logic [31:0] mm [1024];
  bit          mv [1024];

  logic [31:0] e_real;
  logic [31:0] e_raw;
  logic [9:0]  e_addr;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // A code that leaves check bits clean can fix one flipped data bit only.
  function automatic logic [31:0] model_real(
    input logic [31:0] d,
    input logic [31:0] m
  );
    if ($countones(m) <= 1) return d;
    return d ^ m;
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, ".real"}, real_data, e_real);
    chk({tag, ".raw"}, wrong_real_data, e_raw);
    chk({tag, ".addr"}, {22'd0, R_ADDRr}, {22'd0, e_addr});
  endtask

  // Called at a negedge; drives one cycle, then checks at the next negedge.
  task automatic cycle(
    input string       tag,
    input logic        we,
    input logic [9:0]  wa,
    input logic [31:0] din,
    input logic [31:0] msk,
    input logic        re,
    input logic [9:0]  ra
  );
    W_EN    = we;
    W_ADDR  = wa;
    INn     = din;
    selectt = msk;
    R_EN    = re;
    R_ADDR  = ra;
    @(posedge clk);
    if (re) begin
      e_real = model_real(md[ra], mm[ra]);
      e_raw  = md[ra] ^ mm[ra];
      e_addr = ra;
    end
    if (we) begin
      md[wa] = din;
      mm[wa] = msk;
      mv[wa] = 1'b1;
    end
    @(negedge clk);
    W_EN = 1'b0;
    R_EN = 1'b0;
    check_outs(tag);
  endtask

  logic [9:0]  addrs [$];
  logic [31:0] rm;
  logic [9:0]  rwa;
  logic [9:0]  rra;
  logic        rwe;
  logic        rre;
  int          b0;
  int          b1;

  initial begin
    n_chk   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    W_EN    = 1'b0;
    R_EN    = 1'b0;
    W_ADDR  = '0;
    R_ADDR  = '0;
    INn     = '0;
    selectt = '0;
    e_real  = '0;
    e_raw   = '0;
    e_addr  = '0;
    for (int i = 0; i < 1024; i++) mv[i] = 1'b0;
    repeat (2) @(negedge clk);
    check_outs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    cycle("w1", 1, 10'd1, 32'd10, 32'd0, 0, 10'd0);
    cycle("w2", 1, 10'd2, 32'd20, 32'd2, 0, 10'd0);
    cycle("w3", 1, 10'd3, 32'd30, 32'd3, 0, 10'd0);
    cycle("w5", 1, 10'd5, 32'd7, 32'd0, 0, 10'd0);

    cycle("r1", 0, 10'd0, 32'd0, 32'd0, 1, 10'd1);
    chk("r1.lit", real_data, 32'd10);
    cycle("r2", 0, 10'd0, 32'd0, 32'd0, 1, 10'd2);
    chk("r2.real.lit", real_data, 32'd20);
    chk("r2.raw.lit", wrong_real_data, 32'd22);
    cycle("hold", 0, 10'd2, 32'd99, 32'd0, 0, 10'd3);
    chk("hold.addr.lit", {22'd0, R_ADDRr}, 32'd2);
    cycle("r3", 0, 10'd0, 32'd0, 32'd0, 1, 10'd3);
    chk("r3.real.lit", real_data, 32'd29);
    chk("r3.raw.lit", wrong_real_data, 32'd29);

    cycle("rbw", 1, 10'd5, 32'd40, 32'd32, 1, 10'd5);
    chk("rbw.old.lit", real_data, 32'd7);
    cycle("r5", 0, 10'd0, 32'd0, 32'd0, 1, 10'd5);
    chk("r5.real.lit", real_data, 32'd40);
    chk("r5.raw.lit", wrong_real_data, 32'd8);
    cycle("r2b", 0, 10'd0, 32'd0, 32'd0, 1, 10'd2);
    chk("r2b.lit", real_data, 32'd20);

    #2 rst_n = 1'b0;
    #1;
    e_real = '0;
    e_raw  = '0;
    e_addr = '0;
    check_outs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cycle("r1post", 0, 10'd0, 32'd0, 32'd0, 1, 10'd1);
    chk("r1post.lit", real_data, 32'd10);

    for (int n = 0; n < 400; n++) begin
      rwe = 1'($urandom_range(0, 1));
      rwa = 10'($urandom_range(16, 1023));
      if (addrs.size() < 4) rwe = 1'b1;
      rm = '0;
      b0 = $urandom_range(0, 31);
      b1 = $urandom_range(0, 31);
      case ($urandom_range(0, 2))
        0: rm = '0;
        1: rm[b0] = 1'b1;
        default: begin
          if (b1 == b0) b1 = (b0 + 1) % 32;
          rm[b0] = 1'b1;
          rm[b1] = 1'b1;
        end
      endcase
      rre = 1'b0;
      rra = '0;
      if (addrs.size() > 0) begin
        rre = 1'($urandom_range(0, 3) != 0);
        rra = addrs[$urandom_range(0, addrs.size() - 1)];
        if (rwe && $urandom_range(0, 7) == 0 && mv[rwa]) rra = rwa;
      end
      if (rwe && !mv[rwa]) addrs.push_back(rwa);
      cycle("rand", rwe, rwa, $urandom, rm, rre, rra);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
